// File: rtl/alu_exec_unit.sv
// ALU execution unit: one registered operand stage feeding an in-order result FIFO.
// Latency 2 cycles from accept to out_valid; in_ready credits registered occupancy only.
// Backpressure: results queue in the FIFO; the operand stage holds its result only while the FIFO is full.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry,
    output logic             out_zero
);
    localparam int FD = DEPTH - 1;
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             zero;
    } res_t;

    logic             live_q;
    logic             stg_vld_q, stg_vld_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    res_t             mem_q [FD];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    occ;
    logic             fifo_full, push, pop, accept;
    logic [WIDTH:0]   sum, diff;
    res_t             calc, head;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    // live_q keeps in_ready low until the first clock after reset release.
    assign occ       = cnt_q + CW'(stg_vld_q);
    assign in_ready  = live_q && (occ < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign fifo_full = (cnt_q == CW'(FD));
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = stg_vld_q && (!fifo_full || pop);

    assign head      = mem_q[rd_ptr_q];
    assign out_res   = out_valid ? head.res   : '0;
    assign out_carry = out_valid ? head.carry : 1'b0;
    assign out_zero  = out_valid ? head.zero  : 1'b0;

    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = {1'b0, a_q} - {1'b0, b_q};
        calc = '0;
        case (op_q)
            3'b000: begin
                calc.res   = sum[WIDTH-1:0];
                calc.carry = sum[WIDTH];
            end
            3'b001: begin
                calc.res   = diff[WIDTH-1:0];
                calc.carry = diff[WIDTH];
            end
            3'b010: calc.res = a_q & b_q;
            3'b011: calc.res = a_q | b_q;
            3'b100: calc.res = a_q ^ b_q;
            3'b101: calc.res = a_q << b_q[4:0];
            3'b110: calc.res = a_q >> b_q[4:0];
            default: calc.res = a_q * b_q;
        endcase
        calc.zero = (calc.res == '0);
    end

    always_comb begin
        stg_vld_d = accept || (stg_vld_q && !push);
        cnt_d     = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            stg_vld_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            live_q    <= 1'b1;
            stg_vld_q <= stg_vld_d;
            cnt_q     <= cnt_d;
            if (accept) begin
                a_q  <= in_1;
                b_q  <= in_2;
                op_q <= op;
            end
            if (push) begin
                wr_ptr_q <= ptr_nxt(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_nxt(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= calc;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner ops, stall/credit, full throughput, random traffic, async reset.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_1 = '0;
    logic [WIDTH-1:0] in_2 = '0;
    logic [2:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_res;
    logic             out_carry;
    logic             out_zero;

    alu_exec_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_1(in_1), .in_2(in_2), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_carry(out_carry), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        carry;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: 64-bit plain arithmetic, reduced mod 2^32.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        longint unsigned x, y, r;
        exp_t e;
        x = 64'(a);
        y = 64'(b);
        r = 0;
        e = '0;
        case (o)
            3'd0: begin r = x + y; e.carry = (r >= 64'h1_0000_0000); end
            3'd1: begin r = x - y; e.carry = (x < y); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = x << (y % 32);
            3'd6: r = x >> (y % 32);
            default: r = x * y;
        endcase
        e.res  = r[31:0];
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Scoreboard: handshakes are judged at the negedge preceding the edge that completes them.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("out_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 64'({out_res, out_carry, out_zero}), 64'(e));
                end
                delivered++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_1, in_2, op));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        bit ok;
        ok = 1'b0;
        in_1 = a;
        in_2 = b;
        op = o;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout", 64'(ok), 64'd1);
        in_valid = 1'b0;
        in_1 = $urandom;
        in_2 = $urandom;
        op = 3'($urandom);
    endtask

    task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                       input logic [31:0] er, input logic ec, input logic ez);
        send(a, b, o);
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_lat2"}, 64'(out_valid), 64'd1);
        check({tag, "_res"}, 64'({out_res, out_carry, out_zero}), 64'({er, ec, ez}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int base, idx, acc, stalls, gaps, stale;
        bit took;

        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_outs", 64'({out_valid, out_res, out_carry, out_zero}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre_clk", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        dir("add_wrap", 32'hFFFF_FFFF, 32'h1, 3'd0, 32'h0, 1'b1, 1'b1);
        dir("sub_borrow", 32'd5, 32'd7, 3'd1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        dir("sub_plain", 32'd7, 32'd5, 3'd1, 32'h2, 1'b0, 1'b0);
        dir("sll_33", 32'h1, 32'd33, 3'd5, 32'h2, 1'b0, 1'b0);
        dir("srl_31", 32'h8000_0000, 32'd31, 3'd6, 32'h1, 1'b0, 1'b0);
        dir("mul_ovf", 32'h1_0000, 32'h1_0000, 3'd7, 32'h0, 1'b0, 1'b1);
        dir("xor", 32'hF0F0_1234, 32'h0FF0_1234, 3'd4, 32'hFF00_0000, 1'b0, 1'b0);

        // Stall: only DEPTH requests fit, head result must hold.
        out_ready = 1'b0;
        base = delivered;
        idx = 1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_1 = idx; in_2 = idx; op = 3'd0; in_valid = (idx <= 6);
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) acc++;
            if (c >= 3) check("stall_hold", 64'({out_valid, out_res}), 64'({1'b1, 32'd2}));
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        check("stall_accepts", 64'(acc), 64'(DEPTH));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && idx <= 6; c++) begin
            in_1 = idx; in_2 = idx; op = 3'd0; in_valid = 1'b1;
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stall_delivered", 64'(delivered - base), 64'd6);
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Back-to-back throughput.
        base = delivered;
        stalls = 0;
        gaps = 0;
        for (int c = 0; c < 100; c++) begin
            in_1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            in_2 = ($urandom_range(0, 3) == 0) ? 32'(c) : $urandom;
            op = 3'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
            if (c >= 2 && !out_valid) gaps++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("tput_stalls", 64'(stalls), 64'd0);
        check("tput_gaps", 64'(gaps), 64'd0);
        check("tput_count", 64'(delivered - base), 64'd100);

        // Random valid/ready mix exercises full FIFO with simultaneous push/pop.
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_1 = $urandom;
            in_2 = $urandom;
            op = 3'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Async reset with results queued.
        out_ready = 1'b0;
        send(32'd1, 32'd2, 3'd0);
        send(32'd3, 32'd4, 3'd0);
        send(32'd5, 32'd6, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_outs", 64'({out_res, out_carry, out_zero}), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale", 64'(stale), 64'd0);
        @(posedge clk);
        #1;
        dir("post_rst_add", 32'd3, 32'd4, 3'd0, 32'd7, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
